// File: rtl/accum_pkg.sv
// accum_pkg: shared FSM encoding, frame constants and widths for accum_serial.
package accum_pkg;
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    localparam int NUM_PRODUCTS = 8;
    localparam int NUM_WA       = 2;
    localparam int PROD_W       = 16;
    localparam int EST_W        = 15;
endpackage

// File: rtl/accum_add16.sv
// accum_add16: 16-bit modulo adder (no saturation).
// Ports: i_a, i_b operands; o_sum = (i_a + i_b) mod 2^16.
module accum_add16
    import accum_pkg::*;
(
    input  logic [PROD_W-1:0] i_a,
    input  logic [PROD_W-1:0] i_b,
    output logic [PROD_W-1:0] o_sum
);
    assign o_sum = i_a + i_b;
endmodule

// File: rtl/accum_serial.sv
// accum_serial: serial G.726 predictor accumulator, SEZ = (sum WB1..WB6)>>1, SE = (SEZI+WA1+WA2)>>1.
// Ports: clk, reset (async active-low); start/in_valid/WAnWBn frame input; busy/done/SEZ/SE results;
// scan_* and test_mode are DFT hooks with no function; proto_err exists only with ACCUM_ERR_EN defined.
module accum_serial
    import accum_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_in0,
    input  logic              scan_in1,
    input  logic              scan_in2,
    input  logic              scan_in3,
    input  logic              scan_in4,
    input  logic              scan_enable,
    input  logic              test_mode,
    output logic              scan_out0,
    output logic              scan_out1,
    output logic              scan_out2,
    output logic              scan_out3,
    output logic              scan_out4,
    input  logic              start,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] WAnWBn,
    output logic              busy,
    output logic              done,
    output logic [EST_W-1:0]  SEZ,
    output logic [EST_W-1:0]  SE
`ifdef ACCUM_ERR_EN
    ,
    output logic              proto_err
`endif
);
    state_t            r_state, w_state_nxt;
    logic [2:0]        r_cnt, w_cnt_base;
    logic [PROD_W-1:0] r_acc_a, r_acc_b, w_a_base, w_b_base, w_a_nxt, w_b_nxt, w_sum, w_se_sum;
    logic [EST_W-1:0]  r_sez, r_se;
    logic              w_start, w_accept, w_is_wa, w_last, w_dft;
    // DFT inputs are folded into a constant-zero tie-off until scan insertion.
    assign w_dft = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode};
    assign {scan_out0, scan_out1, scan_out2, scan_out3, scan_out4} = {5{w_dft & 1'b0}};
    // A start outside DONE clears the frame in the same cycle, so a product arriving
    // with it is accumulated from a zeroed base as index 0.
    assign w_start    = start & (r_state != DONE);
    assign w_accept   = in_valid & (w_start | (r_state == ACC));
    assign w_cnt_base = w_start ? '0 : r_cnt;
    assign w_a_base   = w_start ? '0 : r_acc_a;
    assign w_b_base   = w_start ? '0 : r_acc_b;
    assign w_is_wa    = w_cnt_base < 3'(NUM_WA);
    assign w_last     = w_accept & (w_cnt_base == 3'(NUM_PRODUCTS - 1));
    accum_add16 u_run (.i_a(w_is_wa ? w_a_base : w_b_base), .i_b(WAnWBn), .o_sum(w_sum));
    assign w_a_nxt = (w_accept & w_is_wa) ? w_sum : w_a_base;
    assign w_b_nxt = (w_accept & ~w_is_wa) ? w_sum : w_b_base;
    // Final sum uses next-state accumulators so results land on the edge entering DONE.
    accum_add16 u_fin (.i_a(w_a_nxt), .i_b(w_b_nxt), .o_sum(w_se_sum));
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = start ? ACC : IDLE;
            ACC:     w_state_nxt = w_last ? DONE : ACC;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_acc_a <= '0;
            r_acc_b <= '0;
            r_sez   <= '0;
            r_se    <= '0;
        end else begin
            r_cnt   <= w_cnt_base + {2'b0, w_accept};
            r_acc_a <= w_a_nxt;
            r_acc_b <= w_b_nxt;
            if (w_last) begin
                r_sez <= w_b_nxt[PROD_W-1:1];
                r_se  <= w_se_sum[PROD_W-1:1];
            end
        end
    end
    assign busy = r_state != IDLE;
    assign done = r_state == DONE;
    assign SEZ  = r_sez;
    assign SE   = r_se;
`ifdef ACCUM_ERR_EN
    logic r_proto_err;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_proto_err <= 1'b0;
        else        r_proto_err <= r_proto_err | (start & (r_state == ACC))
                                 | (in_valid & (((r_state == IDLE) & ~start) | (r_state == DONE)));
    end
    assign proto_err = r_proto_err;
`endif
endmodule

// File: tb/tb_accum_serial.sv
// tb_accum_serial: directed self-checking bench for accum_serial.
module tb_accum_serial;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, in_valid = 1'b0;
    logic [15:0] WAnWBn = '0;
    logic        busy, done;
    logic [14:0] SEZ, SE;
    logic        so0, so1, so2, so3, so4;
`ifdef ACCUM_ERR_EN
    logic        proto_err;
`endif
    int          errors = 0, checks = 0;
    logic [15:0] vec [8];

    always #5 clk = ~clk;

    accum_serial dut (
        .clk(clk), .reset(reset),
        .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0), .scan_in4(1'b0),
        .scan_enable(1'b0), .test_mode(1'b0),
        .scan_out0(so0), .scan_out1(so1), .scan_out2(so2), .scan_out3(so3), .scan_out4(so4),
        .start(start), .in_valid(in_valid), .WAnWBn(WAnWBn),
        .busy(busy), .done(done), .SEZ(SEZ), .SE(SE)
`ifdef ACCUM_ERR_EN
        , .proto_err(proto_err)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic v, input logic [15:0] d);
        start = st;
        in_valid = v;
        WAnWBn = d;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        WAnWBn = '0;
    endtask

    task automatic set_vec(input logic [15:0] wa1, input logic [15:0] wa2, input logic [15:0] wb);
        vec[0] = wa1;
        vec[1] = wa2;
        for (int i = 2; i < 8; i++) vec[i] = wb;
    endtask

    // Runs one frame from vec; a gap of 'gaps' idle cycles precedes product gap_at.
    task automatic run_frame(input int gap_at, input int gaps, input bit merged);
        if (!merged) begin
            cyc(1'b1, 1'b0, '0);
            chk("busy_after_start", {15'b0, busy}, 16'h1);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at)
                for (int g = 0; g < gaps; g++) begin
                    cyc(1'b0, 1'b0, '0);
                    chk("done_in_gap", {15'b0, done}, 16'h0);
                end
            cyc(merged && i == 0, 1'b1, vec[i]);
            if (i < 7) chk("done_early", {15'b0, done}, 16'h0);
        end
        chk("done_pulse", {15'b0, done}, 16'h1);
    endtask

    initial begin
        #12;
        chk("rst_busy", {15'b0, busy}, 16'h0);
        chk("rst_done", {15'b0, done}, 16'h0);
        chk("rst_sez", {1'b0, SEZ}, 16'h0);
        chk("rst_se", {1'b0, SE}, 16'h0);
        chk("rst_scan", {11'b0, so0, so1, so2, so3, so4}, 16'h0);
`ifdef ACCUM_ERR_EN
        chk("rst_perr", {15'b0, proto_err}, 16'h0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        // basic sum
        set_vec(16'h0010, 16'h0020, 16'h0002);
        run_frame(-1, 0, 1'b0);
        chk("basic_sez", {1'b0, SEZ}, 16'h0006);
        chk("basic_se", {1'b0, SE}, 16'h001E);
        cyc(1'b0, 1'b0, '0);
        chk("post_done", {15'b0, done}, 16'h0);
        chk("post_busy", {15'b0, busy}, 16'h0);
        chk("hold_sez", {1'b0, SEZ}, 16'h0006);
        // negative value
        set_vec(16'h0000, 16'h0000, 16'h0000);
        vec[2] = 16'hFFFE;
        run_frame(-1, 0, 1'b0);
        chk("neg_sez", {1'b0, SEZ}, 16'h7FFF);
        chk("neg_se", {1'b0, SE}, 16'h7FFF);
        cyc(1'b0, 1'b0, '0);
        // modulo wrap
        set_vec(16'h0000, 16'h0000, 16'h7FFF);
        run_frame(-1, 0, 1'b0);
        chk("wrap_sez", {1'b0, SEZ}, 16'h7FFD);
        chk("wrap_se", {1'b0, SE}, 16'h7FFD);
        cyc(1'b0, 1'b0, '0);
        // gaps between WB2 and WB3
        set_vec(16'h0010, 16'h0020, 16'h0002);
        run_frame(4, 3, 1'b0);
        chk("gap_sez", {1'b0, SEZ}, 16'h0006);
        chk("gap_se", {1'b0, SE}, 16'h001E);
        cyc(1'b0, 1'b0, '0);
        // start and WA1 in the same cycle
        set_vec(16'h0001, 16'h0002, 16'h0004);
        run_frame(-1, 0, 1'b1);
        chk("merged_sez", {1'b0, SEZ}, 16'h000C);
        chk("merged_se", {1'b0, SE}, 16'h000D);
        cyc(1'b0, 1'b0, '0);
`ifdef ACCUM_ERR_EN
        chk("perr_clean", {15'b0, proto_err}, 16'h0);
`endif
        // abort after four products
        cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 16'h0100);
        chk("abort_no_done", {15'b0, done}, 16'h0);
        set_vec(16'h0010, 16'h0020, 16'h0002);
        cyc(1'b1, 1'b0, '0);
        chk("abort_busy", {15'b0, busy}, 16'h1);
        chk("abort_keep_sez", {1'b0, SEZ}, 16'h000C);
        run_frame(0, 0, 1'b1);
        chk("abort_sez", {1'b0, SEZ}, 16'h0006);
        chk("abort_se", {1'b0, SE}, 16'h001E);
`ifdef ACCUM_ERR_EN
        chk("abort_perr", {15'b0, proto_err}, 16'h1);
`endif
        // start during DONE is ignored
        cyc(1'b1, 1'b0, '0);
        chk("done_start_ign", {15'b0, busy}, 16'h0);
        // in_valid in IDLE is ignored
        cyc(1'b0, 1'b1, 16'h1234);
        chk("idle_valid_ign", {15'b0, busy}, 16'h0);
        chk("idle_valid_sez", {1'b0, SEZ}, 16'h0006);
        // reset mid-frame
        set_vec(16'h0100, 16'h0100, 16'h0100);
        cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, vec[i]);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", {15'b0, busy}, 16'h0);
        chk("mid_rst_sez", {1'b0, SEZ}, 16'h0);
        chk("mid_rst_se", {1'b0, SE}, 16'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, '0);
            chk("mid_rst_no_done", {15'b0, done}, 16'h0);
        end
        set_vec(16'h0010, 16'h0020, 16'h0002);
        run_frame(-1, 0, 1'b0);
        chk("after_rst_sez", {1'b0, SEZ}, 16'h0006);
        chk("after_rst_se", {1'b0, SE}, 16'h001E);
        cyc(1'b0, 1'b0, '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
